// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: synchronises/debounces the start-stop and reset-lap keys and
// sequences the BCD counter (tick enable, clear) and the lap display hold.
module stopwatch_ctrl #(
  parameter int FREQ_MHZ   = 50,
  parameter int TICK_MS    = 100,
  parameter int DEB_CYCLES = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_ss_n,
  input  logic       key_rl_n,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       disp_hold,
  output logic       lap_capture,
  output logic [1:0] state
);

  localparam int TICK_DIV = FREQ_MHZ * 1000 * TICK_MS;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW       = $clog2(DEB_CYCLES);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_LAP   = 2'b11;

  // Key path, bit 0 = start/stop, bit 1 = reset/lap
  logic [1:0]         meta_q, meta_d;
  logic [1:0]         sync_q, sync_d;
  logic [1:0]         arm_q, arm_d;
  logic [1:0]         lvl_q, lvl_d;
  logic [1:0]         evt_q, evt_d;
  logic [1:0][DW-1:0] deb_cnt_q, deb_cnt_d;

  logic          ss_evt, rl_evt;
  logic [1:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          first_q, first_d;
  logic          cnt_en_q, cnt_en_d;
  logic          cnt_clr_q, cnt_clr_d;
  logic          disp_hold_q, disp_hold_d;
  logic          lap_capture_q, lap_capture_d;
  logic          counting, wrap;

  assign ss_evt = evt_q[0];
  assign rl_evt = evt_q[1];

  // A key is only armed after DEB_CYCLES released samples, so a key held
  // through reset cannot fire until it has been let go and pressed again.
  always_comb begin
    meta_d = {key_rl_n, key_ss_n};
    sync_d = meta_q;
    for (int k = 0; k < 2; k++) begin
      arm_d[k]     = arm_q[k];
      lvl_d[k]     = lvl_q[k];
      evt_d[k]     = 1'b0;
      deb_cnt_d[k] = deb_cnt_q[k];
      if (!arm_q[k]) begin
        if (!sync_q[k]) begin
          deb_cnt_d[k] = '0;
        end else if (deb_cnt_q[k] == DW'(DEB_CYCLES - 1)) begin
          arm_d[k]     = 1'b1;
          deb_cnt_d[k] = '0;
        end else begin
          deb_cnt_d[k] = deb_cnt_q[k] + 1'b1;
        end
      end else if (sync_q[k] == lvl_q[k]) begin
        deb_cnt_d[k] = '0;
      end else if (deb_cnt_q[k] == DW'(DEB_CYCLES - 1)) begin
        lvl_d[k]     = sync_q[k];
        evt_d[k]     = ~sync_q[k];
        deb_cnt_d[k] = '0;
      end else begin
        deb_cnt_d[k] = deb_cnt_q[k] + 1'b1;
      end
    end
  end

  // Synchroniser resets to "pressed" so its stale contents never count as release
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q    <= '0;
      sync_q    <= '0;
      arm_q     <= '0;
      lvl_q     <= '1;
      evt_q     <= '0;
      deb_cnt_q <= '0;
    end else begin
      meta_q    <= meta_d;
      sync_q    <= sync_d;
      arm_q     <= arm_d;
      lvl_q     <= lvl_d;
      evt_q     <= evt_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Start/stop takes priority over reset/lap when both fire together
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ss_evt) state_d = S_RUN;
      S_RUN:   if (ss_evt) state_d = S_PAUSE; else if (rl_evt) state_d = S_LAP;
      S_PAUSE: if (ss_evt) state_d = S_RUN;   else if (rl_evt) state_d = S_IDLE;
      S_LAP:   if (ss_evt) state_d = S_PAUSE; else if (rl_evt) state_d = S_RUN;
    endcase
  end

  always_comb begin
    counting      = (state_q == S_RUN) || (state_q == S_LAP);
    wrap          = counting && (presc_q == PW'(TICK_DIV - 1));
    first_d       = 1'b0;
    cnt_clr_d     = first_q || (rl_evt && !ss_evt &&
                    ((state_q == S_IDLE) || (state_q == S_PAUSE)));
    lap_capture_d = (state_q == S_RUN) && (state_d == S_LAP);
    disp_hold_d   = (state_d == S_LAP);
    cnt_en_d      = wrap && !cnt_clr_d;
    if (state_d == S_IDLE)  presc_d = '0;
    else if (wrap)          presc_d = '0;
    else if (counting)      presc_d = presc_q + 1'b1;
    else                    presc_d = presc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q       <= '0;
      first_q       <= 1'b1;
      cnt_en_q      <= 1'b0;
      cnt_clr_q     <= 1'b1;
      disp_hold_q   <= 1'b0;
      lap_capture_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      first_q       <= first_d;
      cnt_en_q      <= cnt_en_d;
      cnt_clr_q     <= cnt_clr_d;
      disp_hold_q   <= disp_hold_d;
      lap_capture_q <= lap_capture_d;
    end
  end

  assign cnt_en      = cnt_en_q;
  assign cnt_clr     = cnt_clr_q;
  assign disp_hold   = disp_hold_q;
  assign lap_capture = lap_capture_q;
  assign state       = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random key activity, all
// compared every cycle against a window-based behavioural model.
module tb_stopwatch_ctrl;
  localparam int DEB = 4;
  localparam int DIV = 1000;
  localparam int IDLE = 0, RUN = 1, PAUSE = 2, LAP = 3;

  logic clk = 1'b0, rst = 1'b1, key_ss_n = 1'b1, key_rl_n = 1'b1;
  logic cnt_en, cnt_clr, disp_hold, lap_capture;
  logic [1:0] state;
  logic [5:0] dut_o;

  stopwatch_ctrl #(.FREQ_MHZ(1), .TICK_MS(1), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .key_ss_n(key_ss_n), .key_rl_n(key_rl_n),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr), .disp_hold(disp_hold),
    .lap_capture(lap_capture), .state(state)
  );

  always #5 clk = ~clk;
  assign dut_o = {state, cnt_en, cnt_clr, disp_hold, lap_capture};

  int vectors = 0, errors = 0, cycle = 0, last_en = 0;

  // Model: raw key history, a key level flips once the last DEB synced samples
  // (raw delayed by two clocks) all disagree with it.
  int m_state, m_presc;
  bit m_en, m_clr, m_hold, m_cap, m_first;
  bit hist [2][DEB+2];
  bit m_arm [2];
  bit m_lvl [2];
  bit m_evt [2];

  function automatic bit win_all(int k, bit v);
    for (int i = 2; i <= DEB + 1; i++) if (hist[k][i] != v) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [5:0] mdl_o();
    return {2'(m_state), m_en, m_clr, m_hold, m_cap};
  endfunction

  task automatic model_step();
    bit raw [2];
    bit nevt [2];
    int ns;
    bit clr, cap, en;
    raw[0] = key_ss_n;
    raw[1] = key_rl_n;
    if (rst) begin
      m_state = IDLE; m_presc = 0; m_en = 0; m_clr = 1; m_hold = 0; m_cap = 0; m_first = 1;
      for (int k = 0; k < 2; k++) begin
        m_arm[k] = 0; m_lvl[k] = 1; m_evt[k] = 0;
        for (int i = 0; i < DEB + 2; i++) hist[k][i] = 0;
      end
      return;
    end
    ns = m_state; clr = m_first; cap = 0; en = 0;
    case (m_state)
      IDLE:  if (m_evt[0]) ns = RUN;   else if (m_evt[1]) clr = 1;
      RUN:   if (m_evt[0]) ns = PAUSE; else if (m_evt[1]) begin ns = LAP; cap = 1; end
      PAUSE: if (m_evt[0]) ns = RUN;   else if (m_evt[1]) begin ns = IDLE; clr = 1; end
      default: if (m_evt[0]) ns = PAUSE; else if (m_evt[1]) ns = RUN;
    endcase
    if (ns == IDLE) m_presc = 0;
    else if (m_state == RUN || m_state == LAP) begin
      if (m_presc == DIV - 1) begin m_presc = 0; en = 1; end
      else m_presc++;
    end
    m_en = en && !clr; m_clr = clr; m_cap = cap; m_hold = (ns == LAP);
    m_state = ns; m_first = 0;
    for (int k = 0; k < 2; k++) begin
      for (int i = DEB + 1; i > 0; i--) hist[k][i] = hist[k][i-1];
      hist[k][0] = raw[k];
      nevt[k] = 0;
      if (!m_arm[k]) m_arm[k] = win_all(k, 1'b1);
      else if (m_lvl[k] && win_all(k, 1'b0)) begin m_lvl[k] = 0; nevt[k] = 1; end
      else if (!m_lvl[k] && win_all(k, 1'b1)) m_lvl[k] = 1;
      m_evt[k] = nevt[k];
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cycle++;
  endtask

  task automatic test_reset();
    int n_en = 0;
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      vectors++;
      if (cnt_clr !== 1'b1 || state !== 2'd0)
        begin errors++; $display("FAIL reset_hold: clr=%b state=%b want 1/00", cnt_clr, state); end
    end
    rst = 0;
    cyc();
    vectors++;
    if (cnt_clr !== 1'b1) begin errors++; $display("FAIL clr_first: got %b want 1", cnt_clr); end
    cyc();
    vectors++;
    if (cnt_clr !== 1'b0) begin errors++; $display("FAIL clr_drop: got %b want 0", cnt_clr); end
    repeat (5000) begin
      cyc();
      if (cnt_en) n_en++;
      vectors++;
      if (dut_o !== mdl_o()) begin errors++; $display("FAIL idle cyc %0d: got %b want %b", cycle, dut_o, mdl_o()); end
    end
    vectors++;
    if (n_en != 0) begin errors++; $display("FAIL idle_en: %0d pulses, want 0", n_en); end
  endtask

  task automatic test_start();
    int run_at = 0, n = 0;
    for (int i = 1; i <= 3100; i++) begin
      key_ss_n = !(i <= 10);
      cyc();
      vectors++;
      if (dut_o !== mdl_o()) begin errors++; $display("FAIL start cyc %0d: got %b want %b", cycle, dut_o, mdl_o()); end
      if (i == 6) begin
        vectors++;
        if (state !== 2'd0) begin errors++; $display("FAIL start_early: state %b want 00", state); end
      end
      if (i == 7) begin
        run_at = cycle;
        vectors++;
        if (state !== 2'd1) begin errors++; $display("FAIL start_run: state %b want 01", state); end
      end
      if (cnt_en) begin
        n++;
        vectors++;
        if (cycle - ((n == 1) ? run_at : last_en) != DIV)
          begin errors++; $display("FAIL tick_space: gap %0d want %0d", cycle - ((n == 1) ? run_at : last_en), DIV); end
        last_en = cycle;
      end
    end
    vectors++;
    if (n != 3) begin errors++; $display("FAIL tick_count: %0d want 3", n); end
  endtask

  task automatic test_bounce();
    for (int i = 1; i <= 60; i++) begin
      key_ss_n = (i <= 20) ? 1'(((i - 1) / 2) % 2) : 1'b1;
      cyc();
      if (cnt_en) last_en = cycle;
      vectors++;
      if (dut_o !== mdl_o() || state !== 2'd1)
        begin errors++; $display("FAIL bounce cyc %0d: got %b want %b (state 01)", cycle, dut_o, mdl_o()); end
    end
  endtask

  task automatic test_lap();
    int caps = 0;
    logic prev_hold = 1'b0;
    for (int i = 1; i <= 2200; i++) begin
      key_rl_n = !(i <= 10 || (i >= 1100 && i < 1110));
      cyc();
      vectors++;
      if (dut_o !== mdl_o()) begin errors++; $display("FAIL lap cyc %0d: got %b want %b", cycle, dut_o, mdl_o()); end
      if (lap_capture) begin
        caps++;
        vectors++;
        if (!(disp_hold === 1'b1 && prev_hold === 1'b0))
          begin errors++; $display("FAIL lap_edge: hold %b prev %b want 1/0", disp_hold, prev_hold); end
      end
      if (i == 7) begin
        vectors++;
        if (state !== 2'd3 || disp_hold !== 1'b1)
          begin errors++; $display("FAIL lap_enter: state %b hold %b want 11/1", state, disp_hold); end
      end
      if (i == 1107) begin
        vectors++;
        if (state !== 2'd1 || disp_hold !== 1'b0)
          begin errors++; $display("FAIL lap_exit: state %b hold %b want 01/0", state, disp_hold); end
      end
      if (cnt_en) begin
        vectors++;
        if (cycle - last_en != DIV) begin errors++; $display("FAIL lap_tick: gap %0d want %0d", cycle - last_en, DIV); end
        last_en = cycle;
      end
      prev_hold = disp_hold;
    end
    vectors++;
    if (caps != 1) begin errors++; $display("FAIL lap_caps: %0d want 1", caps); end
  endtask

  task automatic test_pause();
    int n_en = 0, res_at = 0, first = -1;
    for (int i = 0; i < 1100 && m_presc != 393; i++) begin
      cyc();
      vectors++;
      if (dut_o !== mdl_o()) begin errors++; $display("FAIL pre_pause cyc %0d: got %b want %b", cycle, dut_o, mdl_o()); end
    end
    vectors++;
    if (m_presc != 393) begin errors++; $display("FAIL pause_sync: prescaler %0d want 393", m_presc); end
    for (int i = 1; i <= 3010; i++) begin
      key_ss_n = !(i <= 10);
      cyc();
      if (i >= 8 && cnt_en) n_en++;
      vectors++;
      if (dut_o !== mdl_o()) begin errors++; $display("FAIL pause cyc %0d: got %b want %b", cycle, dut_o, mdl_o()); end
      if (i == 7) begin
        vectors++;
        if (state !== 2'd2) begin errors++; $display("FAIL pause_enter: state %b want 10", state); end
      end
    end
    vectors++;
    if (n_en != 0) begin errors++; $display("FAIL pause_en: %0d pulses want 0", n_en); end
    for (int i = 1; i <= 700; i++) begin
      key_ss_n = !(i <= 10);
      cyc();
      vectors++;
      if (dut_o !== mdl_o()) begin errors++; $display("FAIL resume cyc %0d: got %b want %b", cycle, dut_o, mdl_o()); end
      if (i == 7) res_at = cycle;
      if (cnt_en && first < 0) first = cycle;
    end
    vectors++;
    if (first - res_at != 600) begin errors++; $display("FAIL resume_tick: %0d want 600", first - res_at); end
  endtask

  task automatic test_both();
    int clr_n = 0, res_at = 0, first = -1;
    for (int i = 1; i <= 1200; i++) begin
      int p, o;
      p = (i - 1) / 30;
      o = (i - 1) % 30;
      key_ss_n = !(o < 10 && (p == 0 || p == 2 || p == 3 || p == 5));
      key_rl_n = !(o < 10 && (p == 1 || p == 2 || p == 4));
      cyc();
      vectors++;
      if (dut_o !== mdl_o()) begin errors++; $display("FAIL both cyc %0d: got %b want %b", cycle, dut_o, mdl_o()); end
      if (p == 2 && cnt_clr) clr_n++;
      if (p == 4 && cnt_clr) clr_n += 10;
      if (i == 37 || i == 127) begin
        vectors++;
        if (state !== 2'd0 || cnt_clr !== 1'b1)
          begin errors++; $display("FAIL clr_idle: state %b clr %b want 00/1", state, cnt_clr); end
      end
      if (i == 90) begin
        vectors++;
        if (state !== 2'd1) begin errors++; $display("FAIL both_run: state %b want 01", state); end
      end
      if (i == 157) res_at = cycle;
      if (i > 157 && cnt_en && first < 0) first = cycle;
    end
    vectors++;
    if (clr_n != 10) begin errors++; $display("FAIL clr_pulses: code %0d want 10", clr_n); end
    vectors++;
    if (first - res_at != DIV) begin errors++; $display("FAIL clr_presc: first tick %0d want %0d", first - res_at, DIV); end
  endtask

  task automatic test_rst_run();
    for (int i = 1; i <= 120; i++) begin
      key_rl_n = !(i <= 10);
      key_ss_n = !(i >= 17 && i <= 60);
      rst = (i == 20 || i == 21);
      cyc();
      vectors++;
      if (dut_o !== mdl_o()) begin errors++; $display("FAIL rst_run cyc %0d: got %b want %b", cycle, dut_o, mdl_o()); end
      if (i == 19) begin
        vectors++;
        if (state !== 2'd3 || disp_hold !== 1'b1)
          begin errors++; $display("FAIL rst_pre: state %b hold %b want 11/1", state, disp_hold); end
      end
      if (i >= 20) begin
        vectors++;
        if (state !== 2'd0 || disp_hold !== 1'b0)
          begin errors++; $display("FAIL rst_held: state %b hold %b want 00/0", state, disp_hold); end
      end
    end
    for (int i = 1; i <= 20; i++) begin
      key_ss_n = !(i <= 10);
      cyc();
      vectors++;
      if (dut_o !== mdl_o()) begin errors++; $display("FAIL rst_repress cyc %0d: got %b want %b", cycle, dut_o, mdl_o()); end
      if (i == 7) begin
        vectors++;
        if (state !== 2'd1) begin errors++; $display("FAIL rst_rearm: state %b want 01", state); end
      end
    end
  endtask

  task automatic test_random();
    int hs = 0, hr = 0;
    repeat (4000) begin
      if (hs == 0) begin key_ss_n = ($urandom_range(0, 3) != 0); hs = $urandom_range(1, 14); end
      else hs--;
      if (hr == 0) begin key_rl_n = ($urandom_range(0, 3) != 0); hr = $urandom_range(1, 14); end
      else hr--;
      cyc();
      vectors++;
      if (dut_o !== mdl_o()) begin errors++; $display("FAIL random cyc %0d: got %b want %b", cycle, dut_o, mdl_o()); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_start();
    test_bounce();
    test_lap();
    test_pause();
    test_both();
    test_rst_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
